serial_compare_ctrl: RTL and testbench
======================================

Name: serial_compare_ctrl

Overview:
- Sequencer that time-shares a single 1-bit magnitude comparator slice to compare two WIDTH-bit unsigned words.
- Compares one bit per cycle, MSB first, and terminates early at the first differing bit.
- Reports the result on one-hot flags f1/f2/f3 (A>B, A==B, A<B) with a start/done handshake.
- Sits between operand registers and downstream logic that needs a multi-bit comparison without a WIDTH-wide parallel comparator.

Parameters:
- WIDTH, 8, operand width in bits; legal range 2..32.
- IDX_W, $clog2(WIDTH), width of the bit-index counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  request a comparison; sampled on the rising edge.
- A  input  WIDTH  operand A; captured on the edge that accepts start.
- B  input  WIDTH  operand B; captured on the edge that accepts start.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse; result is valid.
- f1  output  1  A>B.
- f2  output  1  A==B.
- f3  output  1  A<B.
- bit_idx  output  IDX_W  index of the bit being compared this cycle; debug/visibility only.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; busy=0, done=0; {f1,f2,f3}=3'b000; bit_idx=0; operand registers cleared.
- States: IDLE, RUN, DONE. busy=(state==RUN); done=(state==DONE). Both are registered Moore outputs.
- IDLE:
  - start=1 -> latch A,B into internal regs, bit_idx=WIDTH-1, {f1,f2,f3}=000, go RUN.
  - start=0 -> stay in IDLE.
- RUN, one bit per edge, using the comparator slice on a_reg[bit_idx], b_reg[bit_idx]:
  - a=1,b=0 -> {f1,f2,f3}=100, go DONE.
  - a=0,b=1 -> {f1,f2,f3}=001, go DONE.
  - equal and bit_idx==0 -> {f1,f2,f3}=010, go DONE.
  - equal and bit_idx>0 -> bit_idx decrements, stay in RUN.
- DONE (exactly one cycle):
  - start=1 -> accepted as in IDLE (back-to-back operation).
  - start=0 -> go IDLE.
- Latency: start accepted at edge E0. If the first differing bit is at index i, the result is registered at edge E(WIDTH-i); if A==B, at edge E(WIDTH). done is high for the cycle following that edge.
  - Worst case: start to done-high = WIDTH+1 edges.
  - Best case (MSB differs): 2 edges.
- Result hold: f1..f3 hold their value after DONE until the next start is accepted, which clears them to 000. Exactly one flag is high whenever done=1.
- start while busy (RUN) -> ignored; no queuing; operands not re-latched.
- A/B changes after acceptance have no effect on an in-flight comparison.
- rst_n asserted mid-RUN -> immediate return to reset values. The aborted comparison produces no done pulse.
- bit_idx never wraps: it reaches 0 only on the final equal compare, then the FSM leaves RUN.

Test Plan:
- Reset check: hold rst_n=0 for 3 cycles, with start=1 and random A/B -> busy=0, done=0, f=000, bit_idx=0 throughout.
- MSB differs: WIDTH=8, A=8'hA5, B=8'h25, start one cycle -> busy high for 1 cycle; done pulses 2 edges after the start edge; f=100 held afterwards.
- LSB differs: A=8'h10, B=8'h11 -> 8 RUN cycles, bit_idx sequence 7..0, then done with f=001.
- Equal and back-to-back:
  - A=B=8'h3C -> done after 9 edges with f=010.
  - start held high during DONE with A=8'h00, B=8'hFF -> f clears to 000; new done 2 edges later with f=001.
- start ignored while busy: launch A=8'h01, B=8'h00; pulse start with A=8'hFF, B=8'h00 at RUN cycle 3 -> original run completes at 8 compares with f=100, and no second run starts.
- Reset mid-run, plus WIDTH=3 instance:
  - Deassert rst_n during RUN cycle 4 -> outputs return to reset values and no done pulse.
  - With WIDTH=3, A=3'b101, B=3'b101 -> 3 compares, then f=010.

Source files
------------

// File: rtl/serial_compare_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : serial_compare_ctrl
// Description : Bit-serial magnitude comparator sequencer. A single 1-bit
//               comparator slice is time-shared over the operand width,
//               walking from MSB to LSB one bit per clock and stopping at
//               the first differing bit.
//
// Ports
//   clk      in   1      system clock, rising-edge active
//   rst_n    in   1      asynchronous active-low reset
//   start    in   1      request a comparison (accepted in IDLE or DONE)
//   A, B     in   WIDTH  operands, captured on the edge that accepts start
//   busy     out  1      high while the comparison is running
//   done     out  1      one-cycle pulse, result flags valid
//   f1       out  1      A >  B
//   f2       out  1      A == B
//   f3       out  1      A <  B
//   bit_idx  out  IDX_W  index of the bit compared this cycle (debug)
//
// Revision    : 1.0  initial release
// ============================================================================
module serial_compare_ctrl #(
    parameter int WIDTH = 8,
    parameter int IDX_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic             f1,
    output logic             f2,
    output logic             f3,
    output logic [IDX_W-1:0] bit_idx
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [IDX_W-1:0] c_MSB_IDX = IDX_W'(WIDTH - 1);

    // Flag encoding {f1, f2, f3}
    localparam logic [2:0] c_FLAG_NONE = 3'b000;
    localparam logic [2:0] c_FLAG_GT   = 3'b100;
    localparam logic [2:0] c_FLAG_EQ   = 3'b010;
    localparam logic [2:0] c_FLAG_LT   = 3'b001;

    state_t           state_q,   state_d;
    logic [WIDTH-1:0] a_q,       a_d;
    logic [WIDTH-1:0] b_q,       b_d;
    logic [IDX_W-1:0] bit_idx_q, bit_idx_d;
    logic [2:0]       flags_q,   flags_d;
    logic             busy_q,    busy_d;
    logic             done_q,    done_d;

    // The shared 1-bit comparator slice
    logic w_a_bit;
    logic w_b_bit;
    logic w_slice_gt;
    logic w_slice_lt;

    assign w_a_bit    = a_q[bit_idx_q];
    assign w_b_bit    = b_q[bit_idx_q];
    assign w_slice_gt = w_a_bit & ~w_b_bit;
    assign w_slice_lt = ~w_a_bit & w_b_bit;

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        bit_idx_d = bit_idx_q;
        flags_d   = flags_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                // DONE accepts start exactly like IDLE so back-to-back
                // comparisons lose no cycle.
                if (start) begin
                    a_d       = A;
                    b_d       = B;
                    bit_idx_d = c_MSB_IDX;
                    flags_d   = c_FLAG_NONE;
                    state_d   = ST_RUN;
                end else begin
                    state_d   = ST_IDLE;
                end
            end

            ST_RUN: begin
                // start is deliberately ignored here: no queuing, and the
                // latched operands are not disturbed.
                if (w_slice_gt) begin
                    flags_d = c_FLAG_GT;
                    state_d = ST_DONE;
                end else if (w_slice_lt) begin
                    flags_d = c_FLAG_LT;
                    state_d = ST_DONE;
                end else if (bit_idx_q == '0) begin
                    // Every bit matched; leave before the index could wrap.
                    flags_d = c_FLAG_EQ;
                    state_d = ST_DONE;
                end else begin
                    bit_idx_d = bit_idx_q - 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Moore outputs registered from the next state so they line up
        // with the state register.
        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            bit_idx_q <= '0;
            flags_q   <= c_FLAG_NONE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            bit_idx_q <= bit_idx_d;
            flags_q   <= flags_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign f1      = flags_q[2];
    assign f2      = flags_q[1];
    assign f3      = flags_q[0];
    assign bit_idx = bit_idx_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_compare_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_compare_ctrl
// Description : Self-checking bench for serial_compare_ctrl. Drives a WIDTH=8
//               and a WIDTH=3 instance from shared stimulus and checks the
//               selected instance against a reference computed directly from
//               the operand values.
// Revision    : 1.0  initial release
// ============================================================================
module tb_serial_compare_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] a_drv;
    logic [31:0] b_drv;

    logic       busy8, done8, f1_8, f2_8, f3_8;
    logic [2:0] idx8;
    logic       busy3, done3, f1_3, f2_3, f3_3;
    logic [1:0] idx3;

    int checks = 0;
    int errors = 0;
    logic sel3 = 1'b0;

    serial_compare_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start),
        .A(a_drv[7:0]), .B(b_drv[7:0]),
        .busy(busy8), .done(done8), .f1(f1_8), .f2(f2_8), .f3(f3_8),
        .bit_idx(idx8)
    );

    serial_compare_ctrl #(.WIDTH(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start),
        .A(a_drv[2:0]), .B(b_drv[2:0]),
        .busy(busy3), .done(done3), .f1(f1_3), .f2(f2_3), .f3(f3_3),
        .bit_idx(idx3)
    );

    // Selected instance: {busy, done, f1, f2, f3} and bit index
    logic [4:0]  ctrl8, ctrl3, ctrl_sel;
    logic [31:0] idx_sel;
    assign ctrl8    = {busy8, done8, f1_8, f2_8, f3_8};
    assign ctrl3    = {busy3, done3, f1_3, f2_3, f3_3};
    assign ctrl_sel = sel3 ? ctrl3 : ctrl8;
    assign idx_sel  = sel3 ? {30'd0, idx3} : {29'd0, idx8};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: result from plain magnitude comparison; number of
    // compares from the position of the highest differing bit.
    function automatic logic [2:0] ref_flags(input logic [31:0] a, input logic [31:0] b);
        if (a > b)       return 3'b100;
        else if (a == b) return 3'b010;
        else             return 3'b001;
    endfunction

    function automatic int ref_compares(input int w, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] x;
        x = a ^ b;
        if (x == 0) return w;
        return w - ($clog2(x + 1) - 1);
    endfunction

    // Launch a comparison in the current cycle (instance must be IDLE or
    // DONE), follow it through RUN and return in the cycle where done=1.
    // Operands are scrambled during RUN; at RUN cycle inject_at start is
    // pulsed with A=FF, B=00 and must be ignored.
    task automatic run_cmp(input int w, input logic [31:0] a, input logic [31:0] b,
                           input int inject_at, output logic [2:0] fexp);
        int n;
        fexp  = ref_flags(a, b);
        n     = ref_compares(w, a, b);
        sel3  = (w == 3);
        a_drv = a;
        b_drv = b;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int j = 0; j < n; j++) begin
            chk("run_ctrl", {27'd0, ctrl_sel}, 32'b10000);
            chk("run_idx", idx_sel, 32'(w - 1 - j));
            if (j == inject_at) begin
                a_drv = 32'hFF;
                b_drv = 32'h00;
                start = 1'b1;
            end else begin
                a_drv = $urandom;
                b_drv = $urandom;
            end
            step();
            start = 1'b0;
        end
        chk("done_ctrl", {27'd0, ctrl_sel}, {27'd0, 2'b01, fexp});
    endtask

    // One idle cycle after DONE: no new run, flags held.
    task automatic idle_check(input logic [2:0] fexp);
        step();
        chk("hold_ctrl", {27'd0, ctrl_sel}, {27'd0, 2'b00, fexp});
    endtask

    initial begin
        logic [2:0]  f;
        logic [31:0] ra, rb;
        int          w, prev_w;

        // Reset held with start active and random operands
        rst_n = 1'b0;
        start = 1'b1;
        a_drv = $urandom;
        b_drv = $urandom;
        for (int k = 0; k < 3; k++) begin
            step();
            a_drv = $urandom;
            b_drv = $urandom;
            chk("rst_ctrl8", {27'd0, ctrl8}, 32'd0);
            chk("rst_idx8", {29'd0, idx8}, 32'd0);
            chk("rst_ctrl3", {27'd0, ctrl3}, 32'd0);
            chk("rst_idx3", {30'd0, idx3}, 32'd0);
        end
        start = 1'b0;
        rst_n = 1'b1;
        step();
        chk("post_rst_ctrl8", {27'd0, ctrl8}, 32'd0);

        // MSB differs, LSB differs, equal, then back-to-back from DONE
        run_cmp(8, 32'hA5, 32'h25, -1, f);
        idle_check(f);
        run_cmp(8, 32'h10, 32'h11, -1, f);
        idle_check(f);
        run_cmp(8, 32'h3C, 32'h3C, -1, f);
        run_cmp(8, 32'h00, 32'hFF, -1, f);
        idle_check(f);

        // start pulsed while busy must be ignored
        run_cmp(8, 32'h01, 32'h00, 3, f);
        idle_check(f);
        step();
        chk("no_second_run", {27'd0, ctrl8}, 32'b00100);

        // Reset in the middle of a run: immediate clear, no done afterwards
        sel3  = 1'b0;
        a_drv = 32'h00;
        b_drv = 32'h01;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int j = 0; j < 4; j++) begin
            chk("pre_abort_idx", {29'd0, idx8}, 32'(7 - j));
            step();
        end
        rst_n = 1'b0;
        #1;
        chk("abort_ctrl8", {27'd0, ctrl8}, 32'd0);
        chk("abort_idx8", {29'd0, idx8}, 32'd0);
        step();
        step();
        rst_n = 1'b1;
        for (int j = 0; j < 10; j++) begin
            step();
            chk("abort_quiet", {27'd0, ctrl8}, 32'd0);
        end

        // WIDTH=3 equal operands
        run_cmp(3, 32'h5, 32'h5, -1, f);
        idle_check(f);
        for (int k = 0; k < 10; k++) step();

        // Randomised operands on both widths; back-to-back when the width
        // stays the same, otherwise drain so neither instance is busy.
        prev_w = 3;
        for (int it = 0; it < 40; it++) begin
            w  = ($urandom_range(0, 1) == 0) ? 3 : 8;
            ra = $urandom & ((32'd1 << w) - 1);
            case ($urandom_range(0, 2))
                0:       rb = ra;
                1:       rb = ra ^ (32'd1 << $urandom_range(0, w - 1));
                default: rb = $urandom & ((32'd1 << w) - 1);
            endcase
            if (w != prev_w) begin
                idle_check(f);
                for (int k = 0; k < 10; k++) step();
            end else if ($urandom_range(0, 1) == 0) begin
                idle_check(f);
            end
            run_cmp(w, ra, rb, -1, f);
            prev_w = w;
        end
        idle_check(f);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
